// File: rtl/blackjack_table.sv
// blackjack_table: multi-seat blackjack round controller with card-deck handshake; CHARLIE_RULE_EN makes a full non-bust hand an automatic win
module blackjack_table #(
  parameter int NUM_SEATS    = 2,
  parameter int MAX_CARDS    = 5,
  parameter int DEALER_STAND = 17
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_hit,
  input  logic                   i_stand,
  output logic                   o_cardReq,
  input  logic                   i_cardValid,
  input  logic [3:0]             i_cardRank,
  output logic [NUM_SEATS*6-1:0] o_seatSum,
  output logic [5:0]             o_dealerSum,
  output logic [2:0]             o_state,
  output logic [1:0]             o_activeSeat,
  output logic [NUM_SEATS*2-1:0] o_result,
  output logic                   o_done
);
  typedef enum logic [2:0] {IDLE = 3'd0, DEAL = 3'd1, PLAYER = 3'd2, DEALER = 3'd3, RESOLVE = 3'd4, DONE = 3'd5} state_t;
  localparam int NH = NUM_SEATS + 1;
  localparam logic [2:0] DH = 3'(NUM_SEATS);
  localparam logic [3:0] NS = 4'(NUM_SEATS);
  localparam logic [3:0] LAST_DEAL = 4'(2 * NUM_SEATS + 1);
  localparam logic [1:0] LAST_SEAT = 2'(NUM_SEATS - 1);
  localparam logic [2:0] MAXC = 3'(MAX_CARDS);
  localparam logic [5:0] STAND = 6'(DEALER_STAND);
  state_t state_q, state_d;
  logic req_q, req_d;
  logic [3:0] di_q, di_d;
  logic [1:0] act_q, act_d;
  logic [5:0] up_q, up_d;
  logic [5:0] hard_q [NH];
  logic [5:0] hard_d [NH];
  logic ace_q [NH];
  logic ace_d [NH];
  logic [2:0] cnt_q [NH];
  logic [2:0] cnt_d [NH];
  logic [1:0] res_q [NUM_SEATS];
  logic [1:0] res_d [NUM_SEATS];
  logic [5:0] val, a_sum, d_sum, s;
  logic [2:0] tgt, a_cnt;
  logic take, all_bust, d_nat, nat, ch;
  function automatic logic [5:0] best(input logic [5:0] h, input logic a);
    return (a && h <= 6'd11) ? h + 6'd10 : h;
  endfunction
  always_comb begin
    val = i_cardRank >= 4'd10 ? 6'd10 : {2'b00, i_cardRank};
    take = req_q & i_cardValid;
    d_sum = best(hard_q[NUM_SEATS], ace_q[NUM_SEATS]);
    d_nat = cnt_q[NUM_SEATS] == 3'd2 && d_sum == 6'd21;
    a_sum = '0;
    a_cnt = '0;
    all_bust = 1'b1;
    s = '0;
    nat = 1'b0;
    ch = 1'b0;
    for (int i = 0; i < NUM_SEATS; i++) begin
      if (act_q == 2'(i)) begin
        a_sum = best(hard_q[i], ace_q[i]);
        a_cnt = cnt_q[i];
      end
      all_bust &= hard_q[i] > 6'd21;
    end
    tgt = state_q == DEALER ? DH :
          state_q == PLAYER ? {1'b0, act_q} :
          di_q < NS ? di_q[2:0] :
          (di_q == NS || di_q == LAST_DEAL) ? DH : 3'(di_q - NS - 4'd1);
    state_d = state_q;
    req_d = req_q;
    di_d = di_q;
    act_d = act_q;
    up_d = up_q;
    hard_d = hard_q;
    ace_d = ace_q;
    cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      IDLE, DONE: if (i_start) begin
        state_d = DEAL;
        req_d = 1'b1;
        di_d = '0;
        act_d = '0;
        up_d = '0;
        for (int i = 0; i < NH; i++) begin
          hard_d[i] = '0;
          ace_d[i] = 1'b0;
          cnt_d[i] = '0;
        end
        for (int i = 0; i < NUM_SEATS; i++) res_d[i] = '0;
      end
      DEAL: begin
        req_d = !(take);
        if (take) begin
          di_d = di_q + 4'd1;
          if (di_q == LAST_DEAL) begin
            req_d = 1'b0;
            state_d = PLAYER;
            act_d = '0;
          end
        end
      end
      PLAYER: begin
        if (req_q) req_d = !i_cardValid;
        else if (a_sum >= 6'd21 || a_cnt == MAXC || i_stand) begin
          act_d = act_q == LAST_SEAT ? act_q : act_q + 2'd1;
          state_d = act_q == LAST_SEAT ? DEALER : PLAYER;
        end else if (i_hit) req_d = 1'b1;
      end
      DEALER: begin
        if (req_q) req_d = !i_cardValid;
        else if (all_bust || d_sum >= STAND || cnt_q[NUM_SEATS] == MAXC) state_d = RESOLVE;
        else req_d = 1'b1;
      end
      RESOLVE: begin
        state_d = DONE;
        for (int i = 0; i < NUM_SEATS; i++) begin
          s = best(hard_q[i], ace_q[i]);
          nat = cnt_q[i] == 3'd2 && s == 6'd21;
`ifdef CHARLIE_RULE_EN
          ch = cnt_q[i] == MAXC;
`else
          ch = 1'b0;
`endif
          res_d[i] = hard_q[i] > 6'd21 ? 2'b01 :
                     (ch || d_sum > 6'd21 || s > d_sum || (s == d_sum && nat && !d_nat)) ? 2'b11 :
                     (s < d_sum || (s == d_sum && !nat && d_nat)) ? 2'b01 : 2'b10;
        end
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < NH; i++) begin
      if (take && tgt == 3'(i)) begin
        hard_d[i] = hard_q[i] + val;
        cnt_d[i] = cnt_q[i] + 3'd1;
        ace_d[i] = ace_q[i] | (i_cardRank == 4'd1);
      end
    end
    if (take && tgt == DH && cnt_q[NUM_SEATS] == 3'd0) up_d = val;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      di_q <= '0;
      act_q <= '0;
      up_q <= '0;
      for (int i = 0; i < NH; i++) begin
        hard_q[i] <= '0;
        ace_q[i] <= 1'b0;
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < NUM_SEATS; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      di_q <= di_d;
      act_q <= act_d;
      up_q <= up_d;
      hard_q <= hard_d;
      ace_q <= ace_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end
  always_comb begin
    o_seatSum = '0;
    o_result = '0;
    for (int i = 0; i < NUM_SEATS; i++) begin
      o_seatSum[6*i +: 6] = best(hard_q[i], ace_q[i]);
      o_result[2*i +: 2] = res_q[i];
    end
  end
  assign o_cardReq = req_q;
  assign o_state = state_q;
  assign o_activeSeat = act_q;
  assign o_done = state_q == DONE;
  assign o_dealerSum = (state_q == DEALER || state_q == RESOLVE || state_q == DONE) ? d_sum : up_q;
endmodule

// File: tb/tb_blackjack_table.sv
// tb_blackjack_table: table-driven and randomized round checks against a rule-level blackjack model
module tb_blackjack_table;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, hit, stand, req, valid, done;
  logic [3:0] rank, res;
  logic [11:0] seat_sum;
  logic [5:0] dsum;
  logic [2:0] st;
  logic [1:0] act;
  blackjack_table #(.NUM_SEATS(2), .MAX_CARDS(5), .DEALER_STAND(17)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_hit(hit), .i_stand(stand),
    .o_cardReq(req), .i_cardValid(valid), .i_cardRank(rank), .o_seatSum(seat_sum),
    .o_dealerSum(dsum), .o_state(st), .o_activeSeat(act), .o_result(res), .o_done(done)
  );
`ifdef CHARLIE_RULE_EN
  localparam bit CHARLIE = 1'b1;
`else
  localparam bit CHARLIE = 1'b0;
`endif
  int errors = 0;
  int checks = 0;
  int deck[$];
  int used;
  int hits[2];
  int stands[2];
  int exp_up;
  typedef struct {
    logic [63:0] c;
    int n;
    int h0, h1, s0, s1;
    logic [11:0] sums;
    logic [5:0] d, up;
    logic [3:0] res;
    int used;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, a, e);
    end
  endtask
  function automatic int cval(input int r);
    return r > 10 ? 10 : r;
  endfunction
  function automatic int mbest(input int h, input bit a);
    return (a && h + 10 <= 21) ? h + 10 : h;
  endfunction
  task automatic run_round(output bit ok);
    int hd[2];
    int s;
    bit up_seen;
    hd[0] = 0;
    hd[1] = 0;
    up_seen = 1'b0;
    used = 0;
    ok = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      valid = 1'b0;
      hit = 1'b0;
      stand = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (req) begin
        if (deck.size() > 0 && $urandom_range(2) != 0) begin
          valid = 1'b1;
          rank = 4'(deck.pop_front());
          used++;
        end
      end else if ($urandom_range(7) == 0) begin
        valid = 1'b1;
        rank = 4'($urandom_range(13, 1));
      end
      if (st == 3'd2) begin
        if (!up_seen) begin
          chk("upcard_in_player", 32'(dsum), 32'(exp_up));
          up_seen = 1'b1;
        end
        s = int'(act);
        if (!req && s < 2 && $urandom_range(3) != 0) begin
          if (hd[s] < hits[s]) begin
            hit = 1'b1;
            hd[s]++;
          end else if (stands[s] != 0) begin
            stand = 1'b1;
            hit = 1'($urandom_range(1));
          end
        end else if (req) hit = 1'($urandom_range(1));
      end
      @(negedge clk);
    end
  endtask
  task automatic model(output logic [11:0] sums, output logic [5:0] d, output logic [3:0] r, output int nused);
    int hard[3], cnt[3];
    bit ace[3];
    int k, thr, ds, ps, p;
    k = 0;
    for (int h = 0; h < 3; h++) begin
      hard[h] = 0;
      cnt[h] = 0;
      ace[h] = 1'b0;
    end
    for (int rnd = 0; rnd < 2; rnd++)
      for (int h = 0; h < 3; h++) begin
        hard[h] += cval(deck[k]);
        ace[h] |= deck[k] == 1;
        cnt[h]++;
        k++;
      end
    for (int q = 0; q < 2; q++) begin
      thr = $urandom_range(21, 12);
      hits[q] = 0;
      stands[q] = 0;
      while (mbest(hard[q], ace[q]) < 21 && cnt[q] < 5) begin
        if (mbest(hard[q], ace[q]) >= thr) begin
          stands[q] = 1;
          break;
        end
        hard[q] += cval(deck[k]);
        ace[q] |= deck[k] == 1;
        cnt[q]++;
        k++;
        hits[q]++;
      end
    end
    if (!(hard[0] > 21 && hard[1] > 21))
      while (mbest(hard[2], ace[2]) < 17 && cnt[2] < 5) begin
        hard[2] += cval(deck[k]);
        ace[2] |= deck[k] == 1;
        cnt[2]++;
        k++;
      end
    ds = mbest(hard[2], ace[2]);
    d = 6'(ds);
    ds = ds > 21 ? -1 : 2 * ds + ((cnt[2] == 2 && ds == 21) ? 1 : 0);
    for (int q = 0; q < 2; q++) begin
      p = mbest(hard[q], ace[q]);
      ps = 2 * p + ((cnt[q] == 2 && p == 21) ? 1 : 0);
      r[2*q +: 2] = p > 21 ? 2'b01 : (CHARLIE && cnt[q] == 5) ? 2'b11 :
                    ps > ds ? 2'b11 : ps == ds ? 2'b10 : 2'b01;
      sums[6*q +: 6] = 6'(p);
    end
    nused = k;
    exp_up = cval(deck[2]);
  endtask
  task automatic end_checks(input string tag, input logic [11:0] sums, input logic [5:0] d, input logic [3:0] r, input int nused);
    chk({tag, "_seat_sums"}, 32'(seat_sum), 32'(sums));
    chk({tag, "_dealer_sum"}, 32'(dsum), 32'(d));
    chk({tag, "_result"}, 32'(res), 32'(r));
    chk({tag, "_cards_used"}, 32'(used), 32'(nused));
    chk({tag, "_done_state"}, {28'd0, st, done}, {28'd0, 3'd5, 1'b1});
  endtask
  initial begin
    bit ok;
    int taken;
    logic [11:0] es;
    logic [5:0] ed;
    logic [3:0] er;
    int eu;
    v[0] = '{64'hAA79_8A00_0000_0000, 6, 0, 0, 1, 1, {6'd18, 6'd19}, 6'd17, 6'd7, 4'b1111, 6};
    v[1] = '{64'h1AA5_97A2_0000_0000, 8, 2, 0, 1, 1, {6'd19, 6'd18}, 6'd17, 6'd10, 4'b1111, 8};
    v[2] = '{64'hA956_56DC_9000_0000, 9, 1, 1, 0, 0, {6'd24, 6'd26}, 6'd11, 6'd5, 4'b0101, 8};
    v[3] = '{64'h2AA2_AA22_3000_0000, 9, 3, 0, 0, 1, {6'd20, 6'd11}, 6'd20, 6'd10, CHARLIE ? 4'b1011 : 4'b1001, 9};
    v[4] = '{64'h1A7D_74A0_0000_0000, 7, 0, 0, 0, 1, {6'd17, 6'd21}, 6'd21, 6'd7, 4'b0111, 7};
    v[5] = '{64'h1A1D_AD00_0000_0000, 6, 0, 0, 0, 1, {6'd20, 6'd21}, 6'd21, 6'd1, 4'b0110, 6};
    v[6] = '{64'hAAA8_269A_0000_0000, 8, 0, 1, 1, 0, {6'd21, 6'd18}, 6'd26, 6'd10, 4'b1111, 8};
    rst = 1'b1;
    start = 1'b0;
    hit = 1'b0;
    stand = 1'b0;
    valid = 1'b0;
    rank = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(st), 32'd0);
    chk("reset_outputs", {12'd0, req, done, act, res, dsum, 6'd0}, 32'd0);
    chk("reset_seat_sums", 32'(seat_sum), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      deck.delete();
      for (int j = 0; j < v[i].n; j++) deck.push_back(int'(v[i].c[63-4*j -: 4]));
      hits[0] = v[i].h0;
      hits[1] = v[i].h1;
      stands[0] = v[i].s0;
      stands[1] = v[i].s1;
      exp_up = int'(v[i].up);
      run_round(ok);
      chk($sformatf("row%0d_timeout", i), 32'(ok), 32'd1);
      end_checks($sformatf("row%0d", i), v[i].sums, v[i].d, v[i].res, v[i].used);
    end
    for (int t = 0; t < 40; t++) begin
      deck.delete();
      for (int j = 0; j < 24; j++) deck.push_back($urandom_range(13, 1));
      model(es, ed, er, eu);
      run_round(ok);
      chk($sformatf("rand%0d_timeout", t), 32'(ok), 32'd1);
      end_checks($sformatf("rand%0d", t), es, ed, er, eu);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    taken = 0;
    for (int c = 0; c < 40 && taken < 3; c++) begin
      valid = 1'b0;
      if (req) begin
        valid = 1'b1;
        rank = 4'd10;
        taken++;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    for (int c = 0; c < 10 && !req; c++) @(negedge clk);
    chk("reset_mid_req_high", 32'(req), 32'd1);
    rst = 1'b1;
    valid = 1'b1;
    rank = 4'd10;
    @(negedge clk);
    chk("mid_reset_state", 32'(st), 32'd0);
    chk("mid_reset_outputs", {12'd0, req, done, act, res, dsum, 6'd0}, 32'd0);
    chk("mid_reset_seat_sums", 32'(seat_sum), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    chk("post_reset_idle", {29'd0, st}, 32'd0);
    chk("post_reset_no_req", {31'd0, req}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
